mvb_frame_reader: RTL

MVB_FRAME_READER -- requirements
Module: mvb_frame_reader

---
 rtl/mvb_frame_reader_pkg.sv | 35 +++
 rtl/mvb_capture_ram.sv | 33 +++
 rtl/mvb_frame_reader.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/mvb_frame_reader_pkg.sv
// ============================================================================
// Module   : mvb_frame_reader_pkg
// Purpose  : Shared MVB frame-reader types: FSM encoding, status bit map, seed.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mvb_frame_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_LAST = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [15:0] c_seed_default = 16'h7EC3;

  // Status byte layout: {missed, overflow, short, err_in[4:0]}
  localparam int c_st_missed   = 7;
  localparam int c_st_overflow = 6;
  localparam int c_st_short    = 5;
  localparam int c_st_err_lsb  = 0;
  localparam int c_err_w       = 5;

  localparam logic [6:0] c_cnt_max = 7'h7F;

  function automatic logic [15:0] expected_word(input logic [15:0] seed,
                                                input logic [6:0]  idx);
    return seed + {9'd0, idx};
  endfunction

endpackage

`default_nettype wire

// File: rtl/mvb_capture_ram.sv
// ============================================================================
// Module   : mvb_capture_ram
// Purpose  : DEPTH x 16 capture buffer, synchronous write, asynchronous read.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mvb_capture_ram #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [15:0]   i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [15:0]   o_rdata
);

  logic [15:0] mem_q [DEPTH];

  // No reset: contents are undefined until first written.
  always_ff @(posedge clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

`default_nettype wire

// File: rtl/mvb_frame_reader.sv
// ============================================================================
// Module   : mvb_frame_reader
// Purpose  : Drains one decoded MVB frame from the decoder FIFO, checks it
//            against the SEED+k pattern and captures it for display.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mvb_frame_reader
  import mvb_frame_reader_pkg::*;
#(
  parameter int          DEPTH = 16,
  parameter logic [15:0] SEED  = c_seed_default,
  localparam int         AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frame_over,
  input  logic [6:0]    frame_length,
  input  logic [4:0]    err_in,
  input  logic          fifo_empty,
  input  logic [15:0]   fifo_data,
  output logic          fifo_rden,
  input  logic [AW-1:0] rd_addr,
  output logic [15:0]   rd_data,
  output logic          busy,
  output logic          frame_done,
  output logic          frame_ok,
  output logic [6:0]    words_read,
  output logic [6:0]    mismatch_cnt,
  output logic [7:0]    status
);

  localparam logic [7:0] c_depth8 = 8'(DEPTH);

  state_e       state_q, state_d;
  logic [6:0]   len_q, len_d;
  logic [4:0]   err_q, err_d;
  logic [6:0]   issued_q, issued_d;
  logic [6:0]   mis_q, mis_d;
  logic         rvalid_q, rvalid_d;
  logic         missed_q, missed_d;
  logic         short_q, short_d;
  logic         ovf_q, ovf_d;
  logic         hold_q, hold_d;
  logic         drop_q, drop_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         ok_q, ok_d;
  logic [6:0]   words_q, words_d;
  logic [6:0]   miscnt_q, miscnt_d;
  logic [7:0]   status_q, status_d;

  logic         rden;
  logic [6:0]   cap_idx;
  logic         cap_we;

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    err_d    = err_q;
    issued_d = issued_q;
    mis_d    = mis_q;
    missed_d = missed_q;
    short_d  = short_q;
    ovf_d    = ovf_q;
    hold_d   = hold_q;
    drop_d   = drop_q;
    done_d   = 1'b0;
    ok_d     = ok_q;
    words_d  = words_q;
    miscnt_d = miscnt_q;
    status_d = status_q;

    rden     = (state_q == ST_READ) && !fifo_empty && (issued_q < len_q);
    rvalid_d = rden;
    if (rden) begin
      issued_d = issued_q + 7'd1;
    end

    // Data arriving now belongs to the read issued last cycle.
    cap_idx = issued_q - 7'd1;
    cap_we  = rvalid_q && ({1'b0, cap_idx} < c_depth8);
    if (rvalid_q && (fifo_data != expected_word(SEED, cap_idx)) && (mis_q != c_cnt_max)) begin
      mis_d = mis_q + 7'd1;
    end

    case (state_q)
      ST_IDLE: begin
        // A frame_over seen during DONE is only honoured if it is still high now.
        if (hold_q) begin
          hold_d = 1'b0;
          if (!frame_over) begin
            drop_d = 1'b1;
          end
        end
        if (frame_over) begin
          len_d    = frame_length;
          err_d    = err_in;
          issued_d = '0;
          mis_d    = '0;
          missed_d = drop_q;
          drop_d   = 1'b0;
          hold_d   = 1'b0;
          short_d  = (frame_length == 7'd0);
          ovf_d    = ({1'b0, frame_length} > c_depth8);
          state_d  = (frame_length == 7'd0) ? ST_DONE : ST_READ;
        end
      end
      ST_READ: begin
        if (frame_over) begin
          missed_d = 1'b1;
        end
        if (issued_d == len_q) begin
          state_d = ST_LAST;
        end else if (fifo_empty) begin
          short_d = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_LAST: begin
        if (frame_over) begin
          missed_d = 1'b1;
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (frame_over) begin
          hold_d = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Results are published as the FSM enters DONE, including the final capture.
    if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
      done_d   = 1'b1;
      words_d  = issued_d;
      miscnt_d = mis_d;
      status_d = '0;
      status_d[c_st_missed]                  = missed_d;
      status_d[c_st_overflow]                = ovf_d;
      status_d[c_st_short]                   = short_d;
      status_d[c_st_err_lsb +: c_err_w]      = err_d;
      ok_d     = (mis_d == 7'd0) && !short_d && !ovf_d && (err_d == 5'd0);
    end

    busy_d = (state_d == ST_READ) || (state_d == ST_LAST);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      len_q    <= '0;
      err_q    <= '0;
      issued_q <= '0;
      mis_q    <= '0;
      rvalid_q <= 1'b0;
      missed_q <= 1'b0;
      short_q  <= 1'b0;
      ovf_q    <= 1'b0;
      hold_q   <= 1'b0;
      drop_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ok_q     <= 1'b0;
      words_q  <= '0;
      miscnt_q <= '0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      err_q    <= err_d;
      issued_q <= issued_d;
      mis_q    <= mis_d;
      rvalid_q <= rvalid_d;
      missed_q <= missed_d;
      short_q  <= short_d;
      ovf_q    <= ovf_d;
      hold_q   <= hold_d;
      drop_q   <= drop_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ok_q     <= ok_d;
      words_q  <= words_d;
      miscnt_q <= miscnt_d;
      status_q <= status_d;
    end
  end

  mvb_capture_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_capture_ram (
    .clk     (clk),
    .i_we    (cap_we),
    .i_waddr (cap_idx[AW-1:0]),
    .i_wdata (fifo_data),
    .i_raddr (rd_addr),
    .o_rdata (rd_data)
  );

  assign fifo_rden    = rden;
  assign busy         = busy_q;
  assign frame_done   = done_q;
  assign frame_ok     = ok_q;
  assign words_read   = words_q;
  assign mismatch_cnt = miscnt_q;
  assign status       = status_q;

endmodule

`default_nettype wire
